// File: rtl/alu_pkg.sv
// Shared constants for the mashCPU ALU: widths, opcode encoding and flag bit positions.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;
    localparam int FLAG_W = 3;

    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: opcode + operands -> result and C/Z/N.
// Shifts on opcodes 110/111 exist only when ALU_SHIFT_EN is defined; otherwise they pass A.
module alu_core
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] r_o,
    output logic              c_o,
    output logic              z_o,
    output logic              n_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Bit 4 of the 5-bit sum is carry; bit 4 of the difference is borrow (A < B).
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        r_o = '0;
        c_o = 1'b0;
        case (alu_op_e'(op_i))
            OP_ADD: begin
                r_o = sum[DATA_W-1:0];
                c_o = sum[DATA_W];
            end
            OP_SUB: begin
                r_o = diff[DATA_W-1:0];
                c_o = diff[DATA_W];
            end
            OP_AND: r_o = a_i & b_i;
            OP_OR:  r_o = a_i | b_i;
            OP_XOR: r_o = a_i ^ b_i;
            OP_NOT: r_o = ~a_i;
`ifdef ALU_SHIFT_EN
            OP_SHL: begin
                r_o = {a_i[DATA_W-2:0], 1'b0};
                c_o = a_i[DATA_W-1];
            end
            OP_SHR: begin
                r_o = {1'b0, a_i[DATA_W-1:1]};
                c_o = a_i[0];
            end
`else
            OP_SHL: r_o = a_i;
            OP_SHR: r_o = a_i;
`endif
        endcase
    end

    assign z_o = (r_o == '0);
    assign n_o = r_o[DATA_W-1];

endmodule

// File: rtl/alu.sv
// Registered 4-bit ALU: captures core result and flags when Ealu is high; rst wins.
// Optional shifter selected by ALU_SHIFT_EN (see alu_core).
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              Ealu,
    input  logic [OP_W-1:0]   aluOp,
    input  logic [DATA_W-1:0] Ain,
    input  logic [DATA_W-1:0] Bin,
    output logic [DATA_W-1:0] dataOut,
    output logic [FLAG_W-1:0] flagOut
);

    logic [DATA_W-1:0] core_r;
    logic              core_c;
    logic              core_z;
    logic              core_n;

    logic [DATA_W-1:0] data_d, data_q;
    logic [FLAG_W-1:0] flag_d, flag_q;

    alu_core u_core (
        .op_i (aluOp),
        .a_i  (Ain),
        .b_i  (Bin),
        .r_o  (core_r),
        .c_o  (core_c),
        .z_o  (core_z),
        .n_o  (core_n)
    );

    // No handshake: with Ealu high a new result is captured every edge;
    // with Ealu low the registers hold, so operand values (even X) are never sampled.
    always_comb begin
        data_d = data_q;
        flag_d = flag_q;
        if (Ealu) begin
            data_d         = core_r;
            flag_d[FLAG_C] = core_c;
            flag_d[FLAG_Z] = core_z;
            flag_d[FLAG_N] = core_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            flag_q <= '0;
        end else begin
            data_q <= data_d;
            flag_q <= flag_d;
        end
    end

    assign dataOut = data_q;
    assign flagOut = flag_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU; expected values are hand-computed.
module tb_alu;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       Ealu;
    logic [2:0] aluOp;
    logic [3:0] Ain;
    logic [3:0] Bin;
    logic [3:0] dataOut;
    logic [2:0] flagOut;

    int n_checks = 0;
    int n_errors = 0;

    alu dut (
        .clk     (clk),
        .rst     (rst),
        .Ealu    (Ealu),
        .aluOp   (aluOp),
        .Ain     (Ain),
        .Bin     (Bin),
        .dataOut (dataOut),
        .flagOut (flagOut)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic en, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
        rst   = r;
        Ealu  = en;
        aluOp = op;
        Ain   = a;
        Bin   = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, OP_ADD, 4'b0111, 4'b0111);
        step();
        n_checks++;
        if ({dataOut, flagOut} !== 7'b0000_000) begin
            n_errors++;
            $display("FAIL reset: got %b/%b expected 0000/000", dataOut, flagOut);
        end
        drive(1'b0, 1'b0, OP_ADD, 4'b1001, 4'b0011);
        step();
        step();
        n_checks++;
        if ({dataOut, flagOut} !== 7'b0000_000) begin
            n_errors++;
            $display("FAIL enable_low_after_reset: got %b/%b expected 0000/000", dataOut, flagOut);
        end
        Ealu = 1'b1;
        step();
        n_checks++;
        if ({dataOut, flagOut} !== 7'b1100_001) begin
            n_errors++;
            $display("FAIL first_add: got %b/%b expected 1100/001", dataOut, flagOut);
        end
    endtask

    task automatic test_arith();
        logic [2:0] ops [3] = '{OP_ADD, OP_SUB, OP_SUB};
        logic [3:0] as  [3] = '{4'b1111, 4'b1001, 4'b0011};
        logic [3:0] bs  [3] = '{4'b0001, 4'b0011, 4'b1001};
        logic [3:0] er  [3] = '{4'b0000, 4'b0110, 4'b1010};
        logic [2:0] ef  [3] = '{3'b110, 3'b000, 3'b101};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, ops[i], as[i], bs[i]);
            step();
            n_checks++;
            if (dataOut !== er[i] || flagOut !== ef[i]) begin
                n_errors++;
                $display("FAIL arith[%0d]: got %b/%b expected %b/%b", i, dataOut, flagOut, er[i], ef[i]);
            end
        end
    endtask

    // Back-to-back: Ealu stays high and the opcode changes every cycle.
    task automatic test_logic_back_to_back();
        logic [2:0] ops [4] = '{OP_AND, OP_OR, OP_XOR, OP_NOT};
        logic [3:0] er  [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011};
        logic [2:0] ef  [4] = '{3'b001, 3'b001, 3'b000, 3'b000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, ops[i], 4'b1100, 4'b1010);
            step();
            n_checks++;
            if (dataOut !== er[i] || flagOut !== ef[i]) begin
                n_errors++;
                $display("FAIL logic[%0d]: got %b/%b expected %b/%b", i, dataOut, flagOut, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [2:0] ops [2] = '{OP_SHL, OP_SHR};
`ifdef ALU_SHIFT_EN
        logic [3:0] er  [2] = '{4'b0010, 4'b0100};
        logic [2:0] ef  [2] = '{3'b100, 3'b100};
`else
        logic [3:0] er  [2] = '{4'b1001, 4'b1001};
        logic [2:0] ef  [2] = '{3'b001, 3'b001};
`endif
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, ops[i], 4'b1001, 4'b0110);
            step();
            n_checks++;
            if (dataOut !== er[i] || flagOut !== ef[i]) begin
                n_errors++;
                $display("FAIL shift[%0d]: got %b/%b expected %b/%b", i, dataOut, flagOut, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, OP_ADD, 4'b0101, 4'b0100);
        step();
        n_checks++;
        if ({dataOut, flagOut} !== 7'b1001_001) begin
            n_errors++;
            $display("FAIL hold_load: got %b/%b expected 1001/001", dataOut, flagOut);
        end
        drive(1'b0, 1'b0, OP_SUB, 4'b0001, 4'b0010);
        step();
        n_checks++;
        if ({dataOut, flagOut} !== 7'b1001_001) begin
            n_errors++;
            $display("FAIL hold_changed_ops: got %b/%b expected 1001/001", dataOut, flagOut);
        end
        drive(1'b0, 1'b0, OP_XOR, 4'bxxxx, 4'bxxxx);
        step();
        n_checks++;
        if ({dataOut, flagOut} !== 7'b1001_001) begin
            n_errors++;
            $display("FAIL hold_unknown_ops: got %b/%b expected 1001/001", dataOut, flagOut);
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b1, OP_OR, 4'b1111, 4'b1111);
        step();
        n_checks++;
        if ({dataOut, flagOut} !== 7'b0000_000) begin
            n_errors++;
            $display("FAIL reset_priority: got %b/%b expected 0000/000", dataOut, flagOut);
        end
        drive(1'b0, 1'b0, OP_OR, 4'b1111, 4'b1111);
        step();
        n_checks++;
        if ({dataOut, flagOut} !== 7'b0000_000) begin
            n_errors++;
            $display("FAIL hold_after_reset: got %b/%b expected 0000/000", dataOut, flagOut);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, OP_ADD, 4'b0000, 4'b0000);
        test_reset();
        test_arith();
        test_logic_back_to_back();
        test_shift();
        test_hold();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
